// File: rtl/conv_loader_pkg.sv
// ---------------------------------------------------------------------------
// conv_loader_pkg
// Shared convolution parameter header: default geometry of the convolution
// datapath (word width, column depth, input-matrix columns, kernel columns)
// and the clogb2 helper used to size counters throughout the conv blocks.
// No ports.
// ---------------------------------------------------------------------------
package conv_loader_pkg;

    localparam int CONV_BW     = 8;  // bits per data word
    localparam int CONV_ROWS   = 8;  // words per column
    localparam int CONV_COLS   = 8;  // input-matrix columns
    localparam int CONV_HEIGHT = 2;  // kernel columns

    // Number of bits needed to index 0 .. value-1 (never less than 1).
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/conv_loader.sv
// ---------------------------------------------------------------------------
// conv_loader
// Assembles one convolution frame from a word stream: first the kernel
// (rows*height words, column-major) unless a stored kernel is reused, then
// the input matrix (rows*cols words). The finished frame is presented on
// A/kern with out_valid until the consumer acknowledges it.
//
// Handshake: a word moves only on a cycle where in_valid=1 and in_ready=1.
// in_ready is a pure decode of the state register (1 in LOAD_KERN/LOAD_A), so
// it never depends on in_valid. The frame on A/kern is held while out_valid=1
// and released by out_ack=1 in PRESENT.
//
// Ports:
//   clk        in   clock, rising-edge
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle request to load a frame (honoured in IDLE only)
//   keep_kern  in   sampled with start: reuse stored kernel if one is loaded
//   in_valid   in   in_data holds a word
//   in_data    in   stream word, bw bits
//   in_ready   out  loader accepts in_data this cycle
//   A          out  input matrix bus, rows*bw*cols bits
//   kern       out  kernel bus, rows*bw*height bits
//   out_valid  out  A and kern hold a complete frame
//   out_ack    in   consumer releases the presented frame (PRESENT only)
//   busy       out  state is not IDLE
// ---------------------------------------------------------------------------
module conv_loader
    import conv_loader_pkg::*;
#(
    parameter int bw     = CONV_BW,
    parameter int rows   = CONV_ROWS,
    parameter int cols   = CONV_COLS,
    parameter int height = CONV_HEIGHT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       keep_kern,
    input  logic                       in_valid,
    input  logic [bw-1:0]              in_data,
    output logic                       in_ready,
    output logic [rows*bw*cols-1:0]    A,
    output logic [rows*bw*height-1:0]  kern,
    output logic                       out_valid,
    input  logic                       out_ack,
    output logic                       busy
);

    localparam int MAX_COLS = (cols > height) ? cols : height;
    localparam int CNT_W    = clogb2(rows * MAX_COLS);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOAD_KERN = 2'd1;
    localparam logic [1:0] S_LOAD_A    = 2'd2;
    localparam logic [1:0] S_PRESENT   = 2'd3;

    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(rows * height - 1);
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(rows * cols - 1);

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic [CNT_W-1:0]          r_cnt;
    logic [rows*bw*cols-1:0]   r_a;
    logic [rows*bw*height-1:0] r_kern;
    logic                      r_kern_loaded;
    logic                      w_xfer;
    logic                      w_kern_we;
    logic                      w_a_we;

    assign in_ready  = (r_state == S_LOAD_KERN) || (r_state == S_LOAD_A);
    assign out_valid = (r_state == S_PRESENT);
    assign busy      = (r_state != S_IDLE);
    assign A         = r_a;
    assign kern      = r_kern;

    assign w_xfer    = in_valid && in_ready;
    assign w_kern_we = w_xfer && (r_state == S_LOAD_KERN);
    assign w_a_we    = w_xfer && (r_state == S_LOAD_A);

    // Next-state logic. start and out_ack are only looked at in the one
    // state where they mean something, which makes them ignored elsewhere.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // Reuse only works if a kernel actually survived since reset.
                    if (keep_kern && r_kern_loaded) begin
                        w_state_next = S_LOAD_A;
                    end else begin
                        w_state_next = S_LOAD_KERN;
                    end
                end
            end
            S_LOAD_KERN: begin
                if (w_kern_we && (r_cnt == K_LAST)) begin
                    w_state_next = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                if (w_a_we && (r_cnt == A_LAST)) begin
                    w_state_next = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (out_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // One word counter shared by both load phases: any state change restarts
    // it, so the last word of the kernel leaves it at zero for the A phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kern_loaded <= 1'b0;
        end else if (w_kern_we && (r_cnt == K_LAST)) begin
            r_kern_loaded <= 1'b1;
        end
    end

    // Word k of a phase lands in slot k of its bus (k = column*rows + row).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kern <= '0;
        end else begin
            for (int k = 0; k < rows * height; k++) begin
                if (w_kern_we && (r_cnt == CNT_W'(k))) begin
                    r_kern[k*bw +: bw] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
        end else begin
            for (int k = 0; k < rows * cols; k++) begin
                if (w_a_we && (r_cnt == CNT_W'(k))) begin
                    r_a[k*bw +: bw] <= in_data;
                end
            end
        end
    end

endmodule
